// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter
//   Shares one external serial sequence detector among NREQ requesters. A round-robin
//   pick selects a requester, its word is captured, the detector is cleared, and the
//   word is shifted into the detector MSB-first. Match pulses arriving in a fixed
//   WORD_W-cycle window (offset by the detector latency) are counted, saturating. The
//   count is then reported together with the requester index.
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   req          per-requester level request
//   data         requester i word in bits [i*WORD_W +: WORD_W]
//   gnt          one-hot, one-cycle grant/accept pulse
//   det_clear    one-cycle synchronous clear to the detector
//   det_en       det_seq valid this cycle
//   det_seq      serial bit to the detector
//   det_set      detector match pulse
//   busy         high in every state except idle
//   done         one-cycle result strobe
//   done_id      index of the requester being reported (valid with done)
//   done_count   number of matches in the word (valid with done)
module seq_detect_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned DET_LAT = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WORD_W-1:0]    data,
    output logic [NREQ-1:0]           gnt,
    output logic                      det_clear,
    output logic                      det_en,
    output logic                      det_seq,
    input  logic                      det_set,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [CNT_W-1:0]          done_count
);

    localparam int unsigned ID_W   = $clog2(NREQ);
    // step runs 0..WORD_W+DET_LAT-1 across the shift and drain phases
    localparam int unsigned STEP_W = $clog2(WORD_W + DET_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StDrain,
        StReport
    } state_e;

    state_e              state;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     cur_id;
    logic [WORD_W-1:0]   shreg;
    logic [STEP_W-1:0]   step;
    logic [CNT_W-1:0]    count;

    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [NREQ-1:0]     pick_onehot;
    logic [WORD_W-1:0]   pick_word;
    int unsigned         idx;
    logic                in_window;
    logic [CNT_W-1:0]    cnt_next;

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_grant) + k) % NREQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
        pick_onehot          = '0;
        pick_onehot[pick_id] = 1'b1;
        pick_word            = data[32'(pick_id) * WORD_W +: WORD_W];
    end

    // Matches for bit 0 of the word show up DET_LAT cycles after it was presented, so
    // the window is the WORD_W cycles from step DET_LAT through the last drain cycle.
    always_comb begin
        in_window = ((state == StShift) || (state == StDrain)) && (32'(step) >= DET_LAT);
        cnt_next  = count;
        if (in_window && det_set && (count != {CNT_W{1'b1}})) begin
            cnt_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            last_grant <= ID_W'(NREQ - 1);
            cur_id     <= '0;
            shreg      <= '0;
            step       <= '0;
            count      <= '0;
            gnt        <= '0;
            det_clear  <= 1'b0;
            det_en     <= 1'b0;
            det_seq    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            done_count <= '0;
        end else begin
            // one-cycle pulses default low
            gnt       <= '0;
            det_clear <= 1'b0;
            done      <= 1'b0;
            count     <= cnt_next;

            unique case (state)
                StIdle: begin
                    if (pick_found) begin
                        state      <= StClear;
                        shreg      <= pick_word;
                        cur_id     <= pick_id;
                        last_grant <= pick_id;
                        gnt        <= pick_onehot;
                        det_clear  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                StClear: begin
                    state   <= StShift;
                    count   <= '0;
                    step    <= '0;
                    det_en  <= 1'b1;
                    det_seq <= shreg[WORD_W-1];
                    shreg   <= shreg << 1;
                end

                StShift: begin
                    step <= step + 1'b1;
                    if (step == STEP_W'(WORD_W - 1)) begin
                        state   <= StDrain;
                        det_en  <= 1'b0;
                        det_seq <= 1'b0;
                    end else begin
                        det_seq <= shreg[WORD_W-1];
                        shreg   <= shreg << 1;
                    end
                end

                StDrain: begin
                    if (step == STEP_W'(WORD_W + DET_LAT - 1)) begin
                        state      <= StReport;
                        done       <= 1'b1;
                        done_id    <= cur_id;
                        // include the sample taken on this last drain cycle
                        done_count <= cnt_next;
                    end else begin
                        step <= step + 1'b1;
                    end
                end

                StReport: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
module tb_seq_detect_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;

    // instance a: default parameters
    logic [3:0]  gnt;
    logic        det_clear, det_en, det_seq, busy, done;
    logic [1:0]  done_id;
    logic [3:0]  done_count;
    // instance b: one-bit saturating counter
    logic [3:0]  gnt_b;
    logic        det_clear_b, det_en_b, det_seq_b, busy_b, done_b;
    logic [1:0]  done_id_b;
    logic [0:0]  done_count_b;

    logic        force_set = 1'b0;
    logic [31:0] fmask_cur = '0;
    int          rel = 0;

    // behavioural 1101 detectors, latency 2, overlapping, cleared by det_clear
    logic [3:0]  hist [2];
    logic [1:0]  m1;
    logic [1:0]  dset_m;
    logic [1:0]  dclr, den, dseq;
    logic        det_set_a, det_set_b;

    assign dclr      = {det_clear_b, det_clear};
    assign den       = {det_en_b, det_en};
    assign dseq      = {det_seq_b, det_seq};
    assign det_set_a = dset_m[0] | force_set;
    assign det_set_b = dset_m[1] | force_set;

    initial begin
        hist[0] = '0;
        hist[1] = '0;
        m1      = '0;
        dset_m  = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dclr[i]) begin
                hist[i]   <= '0;
                m1[i]     <= 1'b0;
                dset_m[i] <= 1'b0;
            end else begin
                dset_m[i] <= m1[i];
                if (den[i]) begin
                    hist[i] <= {hist[i][2:0], dseq[i]};
                    m1[i]   <= ({hist[i][2:0], dseq[i]} == 4'b1101);
                end else begin
                    m1[i] <= 1'b0;
                end
            end
        end
    end

    seq_detect_arbiter #(.NREQ(4), .WORD_W(8), .DET_LAT(2), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .det_clear  (det_clear),
        .det_en     (det_en),
        .det_seq    (det_seq),
        .det_set    (det_set_a),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .done_count (done_count)
    );

    seq_detect_arbiter #(.NREQ(4), .WORD_W(8), .DET_LAT(2), .CNT_W(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .gnt        (gnt_b),
        .det_clear  (det_clear_b),
        .det_en     (det_en_b),
        .det_seq    (det_seq_b),
        .det_set    (det_set_b),
        .busy       (busy_b),
        .done       (done_b),
        .done_id    (done_id_b),
        .done_count (done_count_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard
    typedef struct {
        int         id;
        logic [7:0] word;
        int         count;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input int id, input logic [7:0] word, input int count);
        exp_t e;
        e.id    = id;
        e.word  = word;
        e.count = count;
        sb.push_back(e);
    endtask

    // forced det_set, indexed by cycle number after the grant (cycle 1 = grant cycle)
    always @(posedge clk) begin
        #1;
        if (gnt != 0) rel = 1;
        else if (rel > 0 && rel < 31) rel = rel + 1;
        else rel = 0;
        force_set = (rel > 0) && fmask_cur[rel];
    end

    // monitor
    logic [7:0] cur_word = '0;
    int         bit_idx = 0;
    int         en_cnt = 0;
    int         g_cyc = 0;
    int         done_seen = 0;
    bit         busy_next = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy_next) begin
                chk("busy_after_report", int'(busy), 0);
                busy_next = 1'b0;
            end
            if (gnt != 0) begin
                if (sb.size() == 0) begin
                    chk("gnt_unexpected", int'(gnt), 0);
                end else begin
                    chk("gnt_onehot", int'(gnt), 1 << sb[0].id);
                    chk("gnt_b_onehot", int'(gnt_b), 1 << sb[0].id);
                    chk("det_clear_with_gnt", int'(det_clear), 1);
                    cur_word = sb[0].word;
                    bit_idx  = 0;
                    en_cnt   = 0;
                    g_cyc    = cyc;
                end
            end
            if (det_en) begin
                en_cnt++;
                if (bit_idx < 8) chk("det_seq", int'(det_seq), int'(cur_word[7 - bit_idx]));
                bit_idx++;
            end
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_id", int'(done_id), e.id);
                    chk("done_count", int'(done_count), e.count);
                    chk("done_b", int'(done_b), 1);
                    chk("done_id_b", int'(done_id_b), e.id);
                    chk("done_count_sat", int'(done_count_b), (e.count > 1) ? 1 : e.count);
                    chk("gnt_to_done", cyc - g_cyc, 11);
                    chk("det_en_cycles", en_cnt, 8);
                    busy_next = 1'b1;
                end
            end
        end
    end

    // drive a held request until n grants are seen, then wait for all results
    task automatic run_hold(input logic [3:0] r, input logic [31:0] d, input logic [31:0] fm,
                            input int n);
        int seen = 0;
        int last_g = 0;
        int t = 0;
        fmask_cur = fm;
        req       = r;
        data      = d;
        while (seen < n && t < 40 * n) begin
            @(negedge clk);
            t++;
            if (gnt != 0) begin
                seen++;
                if (seen > 1) chk("gnt_spacing", cyc - last_g, 13);
                last_g = cyc;
                if (seen == n) req = '0;
            end
        end
        if (seen != n) begin
            chk("gnt_timeout", seen, n);
            req = '0;
        end
        t = 0;
        while ((sb.size() != 0 || busy) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || busy) chk("done_timeout", sb.size(), 0);
        @(negedge clk);
        fmask_cur = '0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [31:0] fmask;
        int          id;
        int          count;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int t;
        int ds;

        tbl[0] = '{4'b0100, 32'h00DD_0000, 32'h0, 2, 2};
        tbl[1] = '{4'b0001, 32'h0000_006D, 32'h0, 0, 2};
        tbl[2] = '{4'b0010, 32'h0000_0000, 32'h0000_000E, 1, 0};   // forced in cycles 1..3
        tbl[3] = '{4'b1000, 32'h0000_0000, 32'h0000_1008, 3, 0};   // forced in cycles 3, 12
        tbl[4] = '{4'b0001, 32'h0000_0000, 32'h0000_0810, 0, 2};   // forced in cycles 4, 11
        tbl[5] = '{4'b0001, 32'h0000_00DD, 32'h0, 0, 2};
        tbl[6] = '{4'b0100, 32'h00B6_0000, 32'h0, 2, 1};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_det_en", int'(det_en), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // single request
        push_exp(0, 8'hDD, 2);
        run_hold(4'b0001, 32'h0000_00DD, 32'h0, 1);

        // round robin from reset priority order: last grant is 0, so start over with reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_exp(0, 8'h6D, 2);
        push_exp(1, 8'hDB, 2);
        push_exp(2, 8'h00, 0);
        push_exp(3, 8'hFF, 0);
        push_exp(0, 8'h6D, 2);
        run_hold(4'b1111, 32'hFF00_DB6D, 32'h0, 5);

        // table vectors: rotation, window masking, saturation
        for (int i = 0; i < 7; i++) begin
            logic [31:0] dv;
            dv = tbl[i].data;
            push_exp(tbl[i].id, dv[tbl[i].id * 8 +: 8], tbl[i].count);
            run_hold(tbl[i].req, tbl[i].data, tbl[i].fmask, 1);
        end

        // requester 2 was served last: search starts at 3 and wraps to 0, then 2
        push_exp(0, 8'hFF, 0);
        push_exp(2, 8'hDB, 2);
        run_hold(4'b0101, 32'h00DB_00FF, 32'h0, 2);

        // reset mid-operation
        push_exp(1, 8'hDD, 2);
        req  = 4'b0010;
        data = 32'h0000_DD00;
        t    = 0;
        while (gnt == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("rst_test_gnt", int'(gnt), 4'b0010);
        req = '0;
        repeat (4) @(negedge clk);
        chk("shift_before_reset", int'(det_en), 1);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_det_clear", int'(det_clear), 0);
        chk("mid_rst_det_en", int'(det_en), 0);
        chk("mid_rst_det_seq", int'(det_seq), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_done_id", int'(done_id), 0);
        chk("mid_rst_done_count", int'(done_count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ds = done_seen;
        repeat (15) @(negedge clk);
        chk("no_done_after_reset", done_seen - ds, 0);
        // with priority restored requester 0 wins over 2
        push_exp(0, 8'hDD, 2);
        run_hold(4'b0101, 32'h0000_0000 | 32'h0000_00DD, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Round-robin arbiter and sequencer that shares one external serial sequence detector among NREQ requesters. It captures a WORD_W-bit word from the granted requester, clears the detector, and shifts the word into it MSB-first. It counts the detector's match pulses for that word and reports the count tagged with the requester index. It sits between the requester blocks and the single detector instance, which nothing else drives.

## Interface
- NREQ, 4: number of requesters (2..8)
- WORD_W, 8: bits per word shifted into the detector
- DET_LAT, 2: detector latency in cycles, from det_seq presented (det_en=1) to det_set for a match ending on that bit; legal range 1..WORD_W
- CNT_W, 4: width of the match counter (saturating)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  NREQ  per-requester request, level
- data  in  NREQ*WORD_W  requester i word in bits [i*WORD_W +: WORD_W]
- gnt  out  NREQ  one-hot, one-cycle grant/accept pulse
- det_clear  out  1  one-cycle synchronous clear to the detector
- det_en  out  1  det_seq valid this cycle
- det_seq  out  1  serial bit to the detector
- det_set  in  1  detector match pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result strobe
- done_id  out  $clog2(NREQ)  index of the requester being reported
- done_count  out  CNT_W  number of matches in the word

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
- IDLE: when req≠0 at an edge, pick the first requester with req set, searching upward from (last_grant+1) mod NREQ.
  - At that edge: capture its word into the shift register, record the id, and update last_grant.
  - Enter CLEAR with gnt one-hot for that cycle.
- CLEAR (1 cycle): det_clear=1, gnt asserted, counters zeroed. Go to SHIFT.
- SHIFT (WORD_W cycles): det_en=1, det_seq=shift-register MSB, shift left each cycle. Go to DRAIN.
- DRAIN (DET_LAT cycles): det_en=0, det_seq=0. Go to REPORT.
- REPORT (1 cycle): done=1, done_id=recorded id, done_count=match count. Go to IDLE.
- Count window: det_set is sampled in exactly WORD_W cycles, starting DET_LAT cycles after the first SHIFT cycle and ending on the last DRAIN cycle.
  - det_set outside the window is ignored.
  - The count increments per sampled-high cycle and saturates at 2^CNT_W−1 (no wrap).
- Handshake:
  - Requester holds req and data stable until it sees its gnt, and may drop req in the gnt cycle.
  - req changes while busy are ignored.
  - A req that drops before being granted is forgotten.
  - A requester still holding req after its grant is eligible again in the next IDLE, at lowest priority.
- Reset values:
  - gnt=0, det_clear=0, det_en=0, det_seq=0, busy=0, done=0, done_id=0, done_count=0.
  - State=IDLE, last_grant=NREQ−1, so requester 0 has first priority.
- Reset mid-operation: immediate return to IDLE. The in-flight word is discarded, no done is issued, and the detector is not cleared until the next CLEAR.
- done_id and done_count hold their last values after REPORT; they are valid only while done=1.

## Timing
- Let E0 be the IDLE edge that samples req≠0.
- Cycle 1: CLEAR, gnt high.
- Cycles 2..WORD_W+1: SHIFT.
- Next DET_LAT cycles: DRAIN.
- Cycle WORD_W+DET_LAT+2: REPORT (defaults: cycle 12).
- Next cycle: IDLE. Earliest next grant is at the end of that IDLE cycle.
- Service period under continuous requests: WORD_W+DET_LAT+3 cycles (defaults: 13).
- gnt to done: WORD_W+DET_LAT+1 cycles.
- All outputs are registered; no combinational path from req or det_set to any output.

## Test plan
Bench uses a behavioural 1101 detector: DET_LAT=2, overlapping matches, cleared by det_clear. Defaults apply.
- Single request: req=0001, data[7:0]=0xDD.
  - gnt=0001 in cycle 1; det_seq bits 1,1,0,1,1,1,0,1 in cycles 2–9.
  - done in cycle 12 with id=0, count=2; busy low in cycle 13.
- Round robin: req=1111 held with words 0x6D, 0xDB, 0x00, 0xFF.
  - Grant order 0,1,2,3,0; counts 2, 2, 0, 0; grants 13 cycles apart.
- Priority rotation: requester 2 served alone, then req=0101 held.
  - Next grant goes to 0 (search starts at 3 and wraps), then 2.
- Saturation: CNT_W=1, word 0xDD.
  - done_count=1 (saturated), not 0.
- Window masking: model forces det_set=1 during CLEAR and the first two SHIFT cycles, word 0x00.
  - done_count=0.
- Reset mid-operation: assert reset during SHIFT.
  - All outputs 0 immediately, no done; the next request is granted to requester 0 with a correct count.
